// File: rtl/seq_pkg.sv
// Shared opcode and state definitions for the program sequencer and its bench.
package seq_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_IMM,
    S_HALT
  } state_e;

endpackage

// File: rtl/prog_mem.sv
// Program store: register array, one synchronous write port, two asynchronous read ports.
module prog_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: no reset branch on purpose; a loaded program must survive Resetn.
  always_ff @(posedge Clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/prog_sequencer.sv
// Feeds a stored program to the 16-bit bus processor one instruction at a time,
// handshaking on Done, with a watchdog and an instruction counter.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int WD_LIMIT = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Fault,
  output logic [7:0]        InstrCount
);

  localparam int                WD_W      = $clog2(WD_LIMIT + 1);
  localparam logic [ADDR_W-1:0] PC_LAST   = '1;
  localparam logic [ADDR_W-1:0] PC_PENULT = PC_LAST - ADDR_W'(1);
  localparam logic [WD_W-1:0]   WD_EXPIRE = WD_W'(WD_LIMIT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              go_q;

  logic [DATA_W-1:0] word0, word1;
  logic [2:0]        op;
  logic              go_rise, idle_like, issue_stop;
  logic [7:0]        cnt_inc;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);
  assign go_rise   = Go && !go_q;

  prog_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .Clock    (Clock),
    .we_i     (LdEn && idle_like),
    .waddr_i  (LdAddr),
    .wdata_i  (LdData),
    .raddr0_i (pc_q),
    .raddr1_i (pc_q + ADDR_W'(1)),
    .rdata0_o (word0),
    .rdata1_o (word1)
  );

  assign op         = word0[DATA_W-1 -: 3];
  // A two-word mvi with no room for its immediate is treated like halt.
  assign issue_stop = (op == OP_HALT) || ((op == OP_MVI) && (pc_q == PC_LAST));
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // NOTE: every next-state signal takes its hold value first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (go_rise) begin
          pc_d    = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d = '0;
        if (issue_stop)         state_d = S_HALT;
        else if (op == OP_MVI)  state_d = S_IMM;
        else                    state_d = S_WAIT;
      end
      S_WAIT, S_IMM: begin
        if (Done) begin
          cnt_d = cnt_inc;
          if ((state_q == S_WAIT) ? (pc_q == PC_LAST) : (pc_q >= PC_PENULT)) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + ((state_q == S_IMM) ? ADDR_W'(2) : ADDR_W'(1));
            state_d = S_ISSUE;
          end
        end else if (wd_q == WD_EXPIRE) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      go_q    <= Go;
    end
  end

  always_comb begin
    DIN = '0;
    Run = 1'b0;
    case (state_q)
      S_ISSUE: begin
        DIN = word0;
        Run = !issue_stop;
      end
      S_WAIT: begin
        DIN = word0;
        Run = 1'b1;
      end
      S_IMM: begin
        DIN = word1;
        Run = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC         = pc_q;
  assign Busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_IMM);
  assign Halted     = (state_q == S_HALT);
  assign Fault      = fault_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench: a program-walking reference model queues every expected Run cycle,
// a processor model answers with Done, and a monitor pops and compares.
module tb_prog_sequencer;
  import seq_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int WD_LIMIT = 8;
  localparam int DEPTH    = 32;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              Go = 1'b0;
  logic              LdEn = 1'b0;
  logic [ADDR_W-1:0] LdAddr = '0;
  logic [DATA_W-1:0] LdData = '0;
  logic              Done = 1'b0;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Busy, Halted, Fault;
  logic [7:0]        InstrCount;

  always #5 Clock = ~Clock;

  prog_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WD_LIMIT(WD_LIMIT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .LdEn(LdEn), .LdAddr(LdAddr),
    .LdData(LdData), .Done(Done), .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy),
    .Halted(Halted), .Fault(Fault), .InstrCount(InstrCount)
  );

  typedef struct {
    int          pc;
    logic [15:0] din;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] tb_mem [DEPTH];
  bit          done_en = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          exp_busy, exp_pc, exp_cnt;
  bit          exp_fault;
  int          tstep = 0;
  logic [2:0]  cur_op = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Processor model: T0 is the issue cycle; Done at T1 for one-step ops, T3 for add/sub.
  always @(negedge Clock) begin
    if (Run) begin
      if (tstep == 0) cur_op = DIN[15:13];
      Done = done_en && (tstep == (((cur_op == OP_ADD) || (cur_op == OP_SUB)) ? 3 : 1));
    end else begin
      Done = 1'b0;
    end
  end

  always @(posedge Clock) begin
    if (!Run || Done) tstep = 0;
    else              tstep = tstep + 1;
  end

  // Monitor: each Run-high cycle must match the next queued (PC, DIN) pair.
  always @(negedge Clock) begin
    exp_t e;
    if (Resetn && Run) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_run: Run high at PC=%0d DIN=0x%0h with nothing expected", PC, DIN);
      end else begin
        e = exp_q.pop_front();
        check("issue_pc", 32'(PC), 32'(e.pc));
        check("issue_din", 32'(DIN), 32'(e.din));
      end
    end
  end

  // Reference: walk the program by the instruction rules and list every Run cycle.
  task automatic model_run(input bit den);
    int pc = 0;
    int cnt = 0;
    int busy = 0;
    int adv, n;
    bit fault = 1'b0;
    logic [15:0] w;
    logic [2:0]  op;
    exp_q.delete();
    while (1) begin
      w  = tb_mem[pc];
      op = w[15:13];
      if ((op == OP_HALT) || ((op == OP_MVI) && (pc == DEPTH - 1))) begin
        busy++;
        break;
      end
      if (!den) begin
        exp_q.push_back('{pc: pc, din: w});
        for (int i = 0; i < WD_LIMIT; i++)
          exp_q.push_back('{pc: pc, din: (op == OP_MVI) ? tb_mem[pc + 1] : w});
        busy += 1 + WD_LIMIT;
        fault = 1'b1;
        break;
      end
      if (op == OP_MVI) begin
        exp_q.push_back('{pc: pc, din: w});
        exp_q.push_back('{pc: pc, din: tb_mem[pc + 1]});
        busy += 2;
        adv = 2;
      end else begin
        n = ((op == OP_ADD) || (op == OP_SUB)) ? 4 : 2;
        for (int i = 0; i < n; i++) exp_q.push_back('{pc: pc, din: w});
        busy += n;
        adv = 1;
      end
      cnt = (cnt < 255) ? cnt + 1 : 255;
      if (pc + adv > DEPTH - 1) break;
      pc += adv;
    end
    exp_busy  = busy;
    exp_pc    = pc;
    exp_cnt   = cnt;
    exp_fault = fault;
  endtask

  task automatic load_word(input int a, input logic [15:0] d);
    @(negedge Clock);
    LdEn   = 1'b1;
    LdAddr = ADDR_W'(a);
    LdData = d;
    tb_mem[a] = d;
    @(posedge Clock);
    #1 LdEn = 1'b0;
  endtask

  // Start with a Go rise, optionally writing word 0 in the same cycle; at busy cycle
  // `poke` try a write to PC+1 and a Go re-rise, both of which must be ignored.
  task automatic run_prog(input string tag, input bit den, input int poke,
                          input bit ld0, input logic [15:0] ld0_word);
    int n = 0;
    @(negedge Clock);
    done_en = den;
    if (ld0) begin
      LdEn = 1'b1; LdAddr = '0; LdData = ld0_word; tb_mem[0] = ld0_word;
    end
    model_run(den);
    Go = 1'b1;
    @(negedge Clock);
    LdEn = 1'b0;
    check({tag, "_go_busy"}, 32'(Busy), 32'd1);
    check({tag, "_go_fault_clear"}, 32'(Fault), 32'd0);
    while (Busy && n < 2000) begin
      n++;
      if (n == poke) begin
        LdEn = 1'b1; LdAddr = PC + ADDR_W'(1); LdData = 16'hE000; Go = 1'b0;
      end else if (n == poke + 1) begin
        LdEn = 1'b0; Go = 1'b1;
      end
      @(negedge Clock);
    end
    LdEn = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    check({tag, "_halted"}, 32'(Halted), 32'd1);
    check({tag, "_pc"}, 32'(PC), 32'(exp_pc));
    check({tag, "_count"}, 32'(InstrCount), 32'(exp_cnt));
    check({tag, "_fault"}, 32'(Fault), 32'(exp_fault));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge Clock);
    check({tag, "_no_retrigger"}, 32'({Halted, Busy}), 32'b10);
    Go = 1'b0;
    done_en = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    int r;
    repeat (3) @(negedge Clock);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_run", 32'(Run), 32'd0);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_count", 32'(InstrCount), 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    // mvi R0,5 ; mv R1,R0 ; halt
    load_word(0, 16'h2000); load_word(1, 16'h0005);
    load_word(2, 16'h0400); load_word(3, 16'hE000);
    run_prog("mvi_prog", 1'b1, 0, 1'b0, 16'h0);
    check("mvi_prog_final_pc", 32'(PC), 32'd3);
    check("mvi_prog_final_count", 32'(InstrCount), 32'd2);

    // add R0,R1 ; mv ; halt
    load_word(0, 16'h4080); load_word(1, 16'h0400); load_word(2, 16'hE000);
    run_prog("add_prog", 1'b1, 0, 1'b0, 16'h0);

    // Watchdog, then a Go rise clears Fault and restarts.
    load_word(0, 16'h0400); load_word(1, 16'hE000);
    run_prog("watchdog", 1'b0, 0, 1'b0, 16'h0);
    check("watchdog_fault_set", 32'(Fault), 32'd1);
    run_prog("after_fault", 1'b1, 0, 1'b0, 16'h0);

    // Full memory of mv, no halt: stop at the last address.
    for (int i = 0; i < DEPTH; i++) load_word(i, 16'h0400 | 16'(i));
    run_prog("full_mem", 1'b1, 0, 1'b0, 16'h0);
    check("full_mem_pc31", 32'(PC), 32'd31);
    check("full_mem_count32", 32'(InstrCount), 32'd32);

    // Reset in the middle of an add.
    load_word(0, 16'h4080); load_word(1, 16'h0400); load_word(2, 16'hE000);
    model_run(1'b1);
    @(negedge Clock); Go = 1'b1;
    repeat (3) @(negedge Clock);
    check("midreset_in_wait", 32'({Run, Busy}), 32'b11);
    Resetn = 1'b0; Go = 1'b0;
    @(negedge Clock);
    check("midreset_run", 32'(Run), 32'd0);
    check("midreset_pc", 32'(PC), 32'd0);
    check("midreset_idle", 32'({Busy, Halted}), 32'b00);
    exp_q.delete();
    Resetn = 1'b1;
    @(negedge Clock);
    run_prog("readback", 1'b1, 0, 1'b0, 16'h0);

    // Write attempted while busy must be dropped.
    load_word(0, 16'h0400); load_word(1, 16'h0401); load_word(2, 16'h0402);
    load_word(3, 16'h0403); load_word(4, 16'hE000);
    run_prog("busy_write", 1'b1, 3, 1'b0, 16'h0);

    // Write in the same cycle as Go is seen by the first issue.
    run_prog("ld_with_go", 1'b1, 0, 1'b1, 16'h4080);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = int'($urandom_range(0, 15));
        w = 16'($urandom);
        if (r < 5)       w[15:13] = OP_MV;
        else if (r < 8)  w[15:13] = OP_MVI;
        else if (r < 10) w[15:13] = OP_ADD;
        else if (r < 12) w[15:13] = OP_SUB;
        else if (r < 15) w[15:13] = 3'($urandom_range(4, 6));
        else             w[15:13] = OP_HALT;
        load_word(i, w);
      end
      run_prog("random", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 6)),
               1'b0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
